wb_sel_pipe: RTL and testbench

Parametrised write-back select stage for the pipelined CPU, sitting between the MEM stage and the register file. It decodes the destination register (rt / rd / link register) and selects the write-back data from NSRC packed sources. Both results are held in a stall/flush-capable pipeline register. It also presents a registered forwarding view to the hazard unit and counts retired instructions.

---
 rtl/wb_sel_pipe.sv | 105 ++++++++++
 tb/tb_wb_sel_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_sel_pipe.sv
// Write-back select stage: decodes the destination register and picks the write-back data.
// Holds both in a stall/flush register, exposes a forwarding view and counts retired instructions.
//
// Ports:
//   clk, reset (async, active-low)
//   stall, flush           hazard-unit control (flush wins)
//   in_valid, regwrite     incoming instruction qualifiers
//   wrsel, wdsel           destination / data-source selects
//   rt, rd, src_data       address fields and packed data sources
//   out_valid, a3, wd, we  registered write-back to the register file
//   fwd_a3, fwd_wd         forwarding view (fwd_a3 = 0 means no forward)
//   retired                count of valid captures

module wb_sel_pipe #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int DSELW   = 2,
  parameter int NSRC    = 4,
  parameter int RA_ADDR = 31,
  parameter int CW      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              regwrite,
  input  logic [1:0]        wrsel,
  input  logic [DSELW-1:0]  wdsel,
  input  logic [AW-1:0]     rt,
  input  logic [AW-1:0]     rd,
  input  logic [NSRC*DW-1:0] src_data,
  output logic              out_valid,
  output logic [AW-1:0]     a3,
  output logic [DW-1:0]     wd,
  output logic              we,
  output logic [AW-1:0]     fwd_a3,
  output logic [DW-1:0]     fwd_wd,
  output logic [CW-1:0]     retired
);

  generate
    if (NSRC < 1 || NSRC > (1 << DSELW)) begin : g_bad_nsrc
      $error("wb_sel_pipe: NSRC must be in 1..2**DSELW");
    end
  endgenerate

  logic [AW-1:0] dec_a3;
  logic [DW-1:0] dec_wd;
  logic          dec_we;
  logic          capture;

  always_comb begin
    dec_a3 = '0;
    unique case (1'b1)
      (wrsel == 2'b00): dec_a3 = rt;
      (wrsel == 2'b01): dec_a3 = rd;
      (wrsel == 2'b10): dec_a3 = AW'(RA_ADDR);
      default:          dec_a3 = '0;
    endcase
  end

  // Codes at or beyond NSRC fall through to zero.
  always_comb begin
    dec_wd = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (wdsel == DSELW'(i))
        dec_wd = src_data[i*DW +: DW];
    end
  end

  // $0 is hard-wired zero, so never enable a write to it.
  assign dec_we  = in_valid & regwrite & (dec_a3 != '0);
  assign capture = ~flush & ~stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      a3        <= '0;
      wd        <= '0;
      we        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      a3        <= '0;
      wd        <= '0;
      we        <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      a3        <= dec_a3;
      wd        <= dec_wd;
      we        <= dec_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      retired <= '0;
    else if (capture && in_valid)
      retired <= retired + CW'(1);
  end

  assign fwd_a3 = we ? a3 : '0;
  assign fwd_wd = wd;

endmodule

// File: tb/tb_wb_sel_pipe.sv
// Directed bench for wb_sel_pipe: decode, data select, stall/flush,
// retire counting (incl. narrow counter wrap) and asynchronous reset.

module tb_wb_sel_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, in_valid, regwrite;
  logic [1:0]  wrsel, wdsel;
  logic [4:0]  rt, rd;
  logic [127:0] src_data;

  logic        ov, we, ov3, we3, ov4, we4;
  logic [4:0]  a3, fa3, a33, fa33, a34, fa34;
  logic [31:0] wd, fwd, wd3, fwd3, wd4, fwd4;
  logic [31:0] ret, ret3;
  logic [3:0]  ret4;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_sel_pipe u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .regwrite(regwrite), .wrsel(wrsel),
    .wdsel(wdsel), .rt(rt), .rd(rd), .src_data(src_data),
    .out_valid(ov), .a3(a3), .wd(wd), .we(we),
    .fwd_a3(fa3), .fwd_wd(fwd), .retired(ret)
  );

  wb_sel_pipe #(.NSRC(3)) u_n3 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .regwrite(regwrite), .wrsel(wrsel),
    .wdsel(wdsel), .rt(rt), .rd(rd), .src_data(src_data[95:0]),
    .out_valid(ov3), .a3(a33), .wd(wd3), .we(we3),
    .fwd_a3(fa33), .fwd_wd(fwd3), .retired(ret3)
  );

  wb_sel_pipe #(.CW(4)) u_c4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .regwrite(regwrite), .wrsel(wrsel),
    .wdsel(wdsel), .rt(rt), .rd(rd), .src_data(src_data),
    .out_valid(ov4), .a3(a34), .wd(wd4), .we(we4),
    .fwd_a3(fa34), .fwd_wd(fwd4), .retired(ret4)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ov"}, 64'(ov), 64'd0);
    chk({tag, ".a3"}, 64'(a3), 64'd0);
    chk({tag, ".wd"}, 64'(wd), 64'd0);
    chk({tag, ".we"}, 64'(we), 64'd0);
    chk({tag, ".fa3"}, 64'(fa3), 64'd0);
  endtask

  task automatic go(input logic v, input logic s, input logic f);
    in_valid = v; stall = s; flush = f;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0; flush = 1'b0;
    in_valid = 1'b1; regwrite = 1'b1;
    wrsel = 2'b00; wdsel = 2'b00; rt = 5'd5; rd = 5'd9;
    src_data = '0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); regwrite = 1'($urandom);
      wrsel = 2'($urandom); wdsel = 2'($urandom);
      rt = 5'($urandom); rd = 5'($urandom);
      src_data = {$urandom, $urandom, $urandom, $urandom};
      stall = 1'($urandom); flush = 1'($urandom);
      tick();
      chk_zero("rst");
      chk("rst.ret", 64'(ret), 64'd0);
    end
    stall = 1'b0; flush = 1'b0;
    in_valid = 1'b1; regwrite = 1'b1;
    rt = 5'd5; rd = 5'd9; wdsel = 2'd0;
    src_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    reset = 1'b1;

    // Destination decode
    wrsel = 2'b00; tick();
    chk("dec00.a3", 64'(a3), 64'd5);
    chk("dec00.we", 64'(we), 64'd1);
    chk("dec00.ov", 64'(ov), 64'd1);
    chk("dec00.fa3", 64'(fa3), 64'd5);
    wrsel = 2'b01; tick();
    chk("dec01.a3", 64'(a3), 64'd9);
    chk("dec01.we", 64'(we), 64'd1);
    wrsel = 2'b10; tick();
    chk("dec10.a3", 64'(a3), 64'd31);
    chk("dec10.we", 64'(we), 64'd1);
    wrsel = 2'b11; tick();
    chk("dec11.a3", 64'(a3), 64'd0);
    chk("dec11.we", 64'(we), 64'd0);
    chk("dec11.fa3", 64'(fa3), 64'd0);
    wrsel = 2'b00; rt = 5'd0; tick();
    chk("rt0.we", 64'(we), 64'd0);
    chk("rt0.fa3", 64'(fa3), 64'd0);
    chk("dec.ret", 64'(ret), 64'd5);

    // Data select
    wrsel = 2'b01;
    wdsel = 2'd0; tick();
    chk("sel0.wd", 64'(wd), 64'hAAAA0000);
    chk("sel0.fwd", 64'(fwd), 64'hAAAA0000);
    wdsel = 2'd1; tick();
    chk("sel1.wd", 64'(wd), 64'hBBBB0001);
    wdsel = 2'd2; tick();
    chk("sel2.wd", 64'(wd), 64'hCCCC0002);
    chk("n3sel2.wd", 64'(wd3), 64'hCCCC0002);
    wdsel = 2'd3; tick();
    chk("sel3.wd", 64'(wd), 64'hDDDD0003);
    chk("n3sel3.wd", 64'(wd3), 64'd0);
    chk("sel.ret", 64'(ret), 64'd9);

    // Stall then stall+flush
    src_data[31:0] = 32'h12345678; wdsel = 2'd0; rd = 5'd9;
    tick();
    chk("cap.a3", 64'(a3), 64'd9);
    chk("cap.wd", 64'(wd), 64'h12345678);
    stall = 1'b1; rd = 5'd3; wdsel = 2'd1; regwrite = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stl.a3", 64'(a3), 64'd9);
      chk("stl.wd", 64'(wd), 64'h12345678);
      chk("stl.we", 64'(we), 64'd1);
      chk("stl.ov", 64'(ov), 64'd1);
      chk("stl.ret", 64'(ret), 64'd10);
    end
    flush = 1'b1; tick();
    chk_zero("sfl");
    chk("sfl.ret", 64'(ret), 64'd10);
    stall = 1'b0; flush = 1'b0; regwrite = 1'b1;

    // Retire count from fresh reset
    reset = 1'b0; tick(); reset = 1'b1;
    chk("rc0.ret", 64'(ret), 64'd0);
    for (int i = 0; i < 5; i++) go(1'b1, 1'b0, 1'b0);
    go(1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) go(1'b1, 1'b0, 1'b0);
    go(1'b1, 1'b0, 1'b1);
    go(1'b0, 1'b0, 1'b0);
    chk("bub.ov", 64'(ov), 64'd0);
    chk("bub.we", 64'(we), 64'd0);
    for (int i = 0; i < 2; i++) go(1'b1, 1'b0, 1'b0);
    chk("rc10.ret", 64'(ret), 64'd10);
    chk("rc10.c4", 64'(ret4), 64'd10);
    for (int i = 0; i < 7; i++) go(1'b1, 1'b0, 1'b0);
    chk("rc17.ret", 64'(ret), 64'd17);
    chk("wrap.c4", 64'(ret4), 64'd1);

    // Asynchronous reset between edges
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 7; i++) go(1'b1, 1'b0, 1'b0);
    chk("pre.ov", 64'(ov), 64'd1);
    chk("pre.ret", 64'(ret), 64'd7);
    #2 reset = 1'b0;
    #1;
    chk_zero("arst");
    chk("arst.ret", 64'(ret), 64'd0);
    tick();
    chk("arsth.ov", 64'(ov), 64'd0);
    chk("arsth.ret", 64'(ret), 64'd0);
    reset = 1'b1;
    tick();
    chk("post.ov", 64'(ov), 64'd1);
    chk("post.ret", 64'(ret), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
